lpgbt_uplink_link_monitor: RTL and testbench

- Per-uplink health monitor for the multi-uplink lpGBT-FPGA 10G24 core. It generalises the single sticky FEC-corrected latch to UPLINKCOUNT channels.
- Each channel provides:
  - a link-state FSM with a stability qualifier,
  - saturating FEC-correction and link-loss counters,
  - a windowed correction-rate snapshot.
- Sits in the uplinkClk_i (40 MHz) domain after cdc_rx. Inputs are already synchronous to uplinkClk_i.

---
 rtl/lpgbt_uplink_link_monitor_pkg.sv | 11 +
 rtl/lpgbt_uplink_mon_chan.sv | 98 +++++++++
 rtl/lpgbt_uplink_link_monitor.sv | 58 +++++
 tb/tb_lpgbt_uplink_link_monitor.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lpgbt_uplink_link_monitor_pkg.sv
// Shared definitions for the per-uplink link monitor.
package lpgbt_uplink_link_monitor_pkg;

  // Per-channel link state; 2'd3 is unused and falls back to DOWN.
  typedef enum logic [1:0] {
    ST_DOWN   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_UP     = 2'd2
  } linkState_t;

endpackage

// File: rtl/lpgbt_uplink_mon_chan.sv
// Single-uplink monitor: link-state FSM with stability qualifier,
// saturating correction/loss counters and windowed rate accumulator.
module lpgbt_uplink_mon_chan
  import lpgbt_uplink_link_monitor_pkg::*;
#(
  parameter int CNT_WIDTH     = 16,
  parameter int STABLE_CYCLES = 64
) (
  input  logic                 uplinkClk_i,
  input  logic                 uplinkRst_i,
  input  logic                 ready_i,
  input  logic                 fecCorrected_i,
  input  logic                 clear_i,
  input  logic                 winEnd_i,
  output logic                 linkUp_o,
  output logic                 fecSeen_o,
  output logic [CNT_WIDTH-1:0] fecCnt_o,
  output logic [CNT_WIDTH-1:0] lossCnt_o,
  output logic [CNT_WIDTH-1:0] fecRate_o
);

  localparam int STB_W = $clog2(STABLE_CYCLES);

  linkState_t           state, stateNxt;
  logic [STB_W-1:0]     settleCnt, settleNxt;
  logic                 lossEv, fecEv;
  logic [CNT_WIDTH-1:0] acc;

  function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] v,
                                                  input logic inc);
    return (inc && (v != '1)) ? v + CNT_WIDTH'(1) : v;
  endfunction

  // State and settle-counter registers.
  always_ff @(posedge uplinkClk_i) begin
    if (uplinkRst_i) begin
      state     <= ST_DOWN;
      settleCnt <= '0;
    end else begin
      state     <= stateNxt;
      settleCnt <= settleNxt;
    end
  end

  // Next-state: ready must stay high STABLE_CYCLES samples before UP.
  always_comb begin
    stateNxt  = state;
    settleNxt = settleCnt;
    lossEv    = 1'b0;
    case (state)
      ST_DOWN: if (ready_i) begin
        stateNxt  = ST_SETTLE;
        settleNxt = STB_W'(1);
      end
      ST_SETTLE: begin
        if (!ready_i)                                  stateNxt = ST_DOWN;
        else if (settleCnt == STB_W'(STABLE_CYCLES-1)) stateNxt = ST_UP;
        else                                           settleNxt = settleCnt + STB_W'(1);
      end
      ST_UP: if (!ready_i) begin
        stateNxt = ST_DOWN;
        lossEv   = 1'b1;
      end
      default: stateNxt = ST_DOWN;
    endcase
  end

  assign linkUp_o = (state == ST_UP);
  // A correction only counts while the link is qualified and still ready.
  assign fecEv    = (state == ST_UP) && ready_i && fecCorrected_i;

  // Totals and sticky flag; clear beats any same-cycle increment.
  always_ff @(posedge uplinkClk_i) begin
    if (uplinkRst_i || clear_i) begin
      fecCnt_o  <= '0;
      lossCnt_o <= '0;
      fecSeen_o <= 1'b0;
    end else begin
      fecCnt_o  <= satInc(fecCnt_o, fecEv);
      lossCnt_o <= satInc(lossCnt_o, lossEv);
      if (fecEv) fecSeen_o <= 1'b1;
    end
  end

  // Window accumulator; the last window cycle's event lands in the snapshot.
  always_ff @(posedge uplinkClk_i) begin
    if (uplinkRst_i) begin
      acc       <= '0;
      fecRate_o <= '0;
    end else if (winEnd_i) begin
      fecRate_o <= satInc(acc, fecEv);
      acc       <= '0;
    end else begin
      acc       <= satInc(acc, fecEv);
    end
  end

endmodule

// File: rtl/lpgbt_uplink_link_monitor.sv
// Multi-uplink health monitor: one channel monitor per uplink plus a
// shared free-running rate window.
module lpgbt_uplink_link_monitor #(
  parameter int UPLINKCOUNT   = 2,
  parameter int CNT_WIDTH     = 16,
  parameter int STABLE_CYCLES = 64,
  parameter int WINDOW_CYCLES = 40000000,
  parameter int WIN_WIDTH     = 26
) (
  input  logic                             uplinkClk_i,
  input  logic                             uplinkRst_i,
  input  logic [UPLINKCOUNT-1:0]           uplinkReady_i,
  input  logic [UPLINKCOUNT-1:0]           fecCorrected_i,
  input  logic [UPLINKCOUNT-1:0]           clear_i,
  output logic [UPLINKCOUNT-1:0]           linkUp_o,
  output logic [UPLINKCOUNT-1:0]           fecSeen_o,
  output logic [UPLINKCOUNT*CNT_WIDTH-1:0] fecCnt_o,
  output logic [UPLINKCOUNT*CNT_WIDTH-1:0] lossCnt_o,
  output logic [UPLINKCOUNT*CNT_WIDTH-1:0] fecRate_o,
  output logic                             winTick_o
);

  logic [WIN_WIDTH-1:0] winCnt;
  logic                 winEnd;

  assign winEnd = (winCnt == WIN_WIDTH'(WINDOW_CYCLES-1));

  // Shared window counter; tick is registered so it aligns with new fecRate_o.
  always_ff @(posedge uplinkClk_i) begin
    if (uplinkRst_i) begin
      winCnt    <= '0;
      winTick_o <= 1'b0;
    end else begin
      winCnt    <= winEnd ? '0 : winCnt + WIN_WIDTH'(1);
      winTick_o <= winEnd;
    end
  end

  for (genvar g = 0; g < UPLINKCOUNT; g++) begin : g_chan
    lpgbt_uplink_mon_chan #(
      .CNT_WIDTH     (CNT_WIDTH),
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_chan (
      .uplinkClk_i    (uplinkClk_i),
      .uplinkRst_i    (uplinkRst_i),
      .ready_i        (uplinkReady_i[g]),
      .fecCorrected_i (fecCorrected_i[g]),
      .clear_i        (clear_i[g]),
      .winEnd_i       (winEnd),
      .linkUp_o       (linkUp_o[g]),
      .fecSeen_o      (fecSeen_o[g]),
      .fecCnt_o       (fecCnt_o[CNT_WIDTH*g +: CNT_WIDTH]),
      .lossCnt_o      (lossCnt_o[CNT_WIDTH*g +: CNT_WIDTH]),
      .fecRate_o      (fecRate_o[CNT_WIDTH*g +: CNT_WIDTH])
    );
  end

endmodule

// File: tb/tb_lpgbt_uplink_link_monitor.sv
// Scoreboard bench for lpgbt_uplink_link_monitor (4 links, 4-bit counters,
// 64-cycle settle, 100-cycle window).
module tb_lpgbt_uplink_link_monitor;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int SC = 64;
  localparam int WC = 100;
  localparam int WW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  ready = '0, fec = '0, clr = '0;
  logic [N-1:0]  linkUp, fecSeen;
  logic [N*CW-1:0] fecCnt, lossCnt, fecRate;
  logic          winTick;

  lpgbt_uplink_link_monitor #(
    .UPLINKCOUNT(N), .CNT_WIDTH(CW), .STABLE_CYCLES(SC),
    .WINDOW_CYCLES(WC), .WIN_WIDTH(WW)
  ) dut (
    .uplinkClk_i(clk), .uplinkRst_i(rst), .uplinkReady_i(ready),
    .fecCorrected_i(fec), .clear_i(clr), .linkUp_o(linkUp),
    .fecSeen_o(fecSeen), .fecCnt_o(fecCnt), .lossCnt_o(lossCnt),
    .fecRate_o(fecRate), .winTick_o(winTick)
  );

  always #5 clk = ~clk;

  // Cycles since reset release (edge number of the last sampling edge).
  int cyc = 0;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  typedef enum {K_UP, K_SEEN, K_CNT, K_LOSS, K_TICK,
                V_UP, V_SEEN, V_CNT, V_LOSS, V_RATE} kind_t;
  typedef struct { string name; kind_t kind; int ch; longint expv; } chk_t;
  typedef struct { int at; logic [N*CW-1:0] rate; } rate_t;

  chk_t  chkQ[$];
  rate_t rateQ[$];
  int    errors = 0, checks = 0, totCyc = 0;
  bit    done = 0, finalDone = 0;
  chk_t  mc;
  rate_t mr;
  longint act;

  function automatic longint actual(kind_t k, int ch);
    case (k)
      K_UP:   return longint'(linkUp[ch]);
      K_SEEN: return longint'(fecSeen[ch]);
      K_CNT:  return longint'(fecCnt[ch*CW +: CW]);
      K_LOSS: return longint'(lossCnt[ch*CW +: CW]);
      K_TICK: return longint'(winTick);
      V_UP:   return longint'(linkUp);
      V_SEEN: return longint'(fecSeen);
      V_CNT:  return longint'(fecCnt);
      V_LOSS: return longint'(lossCnt);
      default: return longint'(fecRate);
    endcase
  endfunction

  // Monitor: drain expected values against the DUT, check each window tick.
  always @(negedge clk) begin
    totCyc++;
    while (chkQ.size() > 0) begin
      mc  = chkQ.pop_front();
      act = actual(mc.kind, mc.ch);
      checks++;
      if (act != mc.expv) begin
        errors++;
        $display("FAIL %s ch%0d cyc%0d: got 0x%0h expected 0x%0h",
                 mc.name, mc.ch, cyc, act, mc.expv);
      end
    end
    if (winTick && rateQ.size() > 0) begin
      mr = rateQ.pop_front();
      checks += 2;
      if (cyc != mr.at) begin
        errors++;
        $display("FAIL tickCycle: got %0d expected %0d", cyc, mr.at);
      end
      if (fecRate != mr.rate) begin
        errors++;
        $display("FAIL tickRate cyc%0d: got 0x%0h expected 0x%0h", cyc, fecRate, mr.rate);
      end
    end
    if (done && !finalDone) begin
      checks++;
      if (rateQ.size() != 0) begin
        errors++;
        $display("FAIL missingTick: got %0d pending expected 0", rateQ.size());
      end
      finalDone = 1;
    end
    if (totCyc > 3000) begin
      $display("FAIL watchdog: got %0d cycles expected < 3000", totCyc);
      $fatal(1);
    end
  end

  task automatic at(int k);
    while (cyc < k) begin @(posedge clk); #1; end
  endtask

  task automatic exp1(string n, kind_t k, int ch, longint e);
    chkQ.push_back('{n, k, ch, e});
  endtask

  task automatic expRate(int a, logic [N*CW-1:0] r);
    rateQ.push_back('{a, r});
  endtask

  task automatic expZero(string n);
    exp1({n, "_up"},   V_UP,   0, 0);
    exp1({n, "_seen"}, V_SEEN, 0, 0);
    exp1({n, "_cnt"},  V_CNT,  0, 0);
    exp1({n, "_loss"}, V_LOSS, 0, 0);
    exp1({n, "_rate"}, V_RATE, 0, 0);
    exp1({n, "_tick"}, K_TICK, 0, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    expZero("reset");
    rst = 1'b0;
    ready = 4'b1101;                         // ch0, ch2, ch3 ready from edge 1

    at(4);   ready[1] = 1'b1;                // ch1 into SETTLE at edge 5
    at(34);  ready[1] = 1'b0;                // drop during SETTLE at edge 35
    at(35);  fec[1] = 1'b1;                  // events while DOWN
    at(38);  fec[1] = 1'b0;
             exp1("downFec", K_CNT, 1, 0);
             exp1("downSeen", K_SEEN, 1, 0);
             exp1("settleDropLoss", K_LOSS, 1, 0);
    at(39);  ready[1] = 1'b1;                // re-rise sampled at edge 40
    at(49);  fec[1] = 1'b1;                  // event while SETTLE
    at(50);  fec[1] = 1'b0;
             exp1("settleFec", K_CNT, 1, 0);
    at(63);  exp1("upEdge63", K_UP, 0, 0);
             exp1("upEdge63", K_UP, 3, 0);
    at(64);  exp1("upEdge64", V_UP, 0, 4'b1101);
    at(69);  fec[0] = 1'b1;                  // 7 events, edges 70..76
             exp1("preFec", K_CNT, 0, 0);
    at(76);  fec[0] = 1'b0;
             exp1("fecCnt7", K_CNT, 0, 7);
             exp1("seenVec", V_SEEN, 0, 4'b0001);
             expRate(100, 16'h0007);
    at(99);  exp1("tick99", K_TICK, 0, 0);
    at(100); exp1("tick100", K_TICK, 0, 1);
             exp1("rate100", V_RATE, 0, 16'h0007);
    at(101); exp1("tick101", K_TICK, 0, 0);
    at(102); exp1("reriseUp102", K_UP, 1, 0);
    at(103); exp1("reriseUp103", K_UP, 1, 1);
             exp1("reriseLoss", K_LOSS, 1, 0);
    at(109); fec[2] = 1'b1;                  // 5 events, edges 110..114
    at(114); fec[2] = 1'b0;
             exp1("fecCnt5", K_CNT, 2, 5);
    at(119); ready[2] = 1'b0;                // loss at edge 120
             exp1("preLossUp", K_UP, 2, 1);
    at(120); fec[2] = 1'b1;                  // events while DOWN, 121..123
             exp1("lossUp", K_UP, 2, 0);
             exp1("lossCnt1", K_LOSS, 2, 1);
             exp1("lossFecCnt", K_CNT, 2, 5);
             exp1("lossSeen", K_SEEN, 2, 1);
    at(123); fec[2] = 1'b0;
             exp1("postLossFec", K_CNT, 2, 5);
    at(149); fec[0] = 1'b1;                  // edges 150, 151
    at(151); fec[0] = 1'b0;
    at(199); fec[0] = 1'b1;                  // last window cycle, edge 200
             expRate(200, 16'h0503);
    at(200); fec[0] = 1'b0;
             exp1("fecCnt10", K_CNT, 0, 10);
             exp1("rate200", V_RATE, 0, 16'h0503);
    at(209); fec[3] = 1'b1;                  // 20 events, edges 210..229
    at(224); exp1("sat15", K_CNT, 3, 15);
    at(229); fec[3] = 1'b0;
             exp1("satHold", K_CNT, 3, 15);
             exp1("satSeen", K_SEEN, 3, 1);
    at(239); fec[3] = 1'b1; clr[3] = 1'b1;   // clear vs event at edge 240
    at(240); clr[3] = 1'b0;
             exp1("clearWins", K_CNT, 3, 0);
             exp1("clearSeen", K_SEEN, 3, 0);
             exp1("clearKeepsRate", V_RATE, 0, 16'h0503);
    at(241); fec[3] = 1'b0;
             exp1("afterClear", K_CNT, 3, 1);
             exp1("afterClearSeen", K_SEEN, 3, 1);
    at(249); ready[0] = 1'b0; clr[0] = 1'b1; // loss and clear at edge 250
    at(250); clr[0] = 1'b0;
             exp1("lossClrUp", K_UP, 0, 0);
             exp1("lossClrLoss", K_LOSS, 0, 0);
             exp1("lossClrCnt", K_CNT, 0, 0);
             exp1("lossVec", V_LOSS, 0, 16'h0100);
             expRate(300, 16'hF000);
    at(300); fec[3] = 1'b1;                  // partial window 4, edges 301..305
             exp1("rate300", V_RATE, 0, 16'hF000);
    at(305); fec[3] = 1'b0;
    at(309); exp1("preRstRate", V_RATE, 0, 16'hF000);
             exp1("preRstLoss", V_LOSS, 0, 16'h0100);
             exp1("preRstCnt", V_CNT, 0, 16'h6500);
             rst = 1'b1;
    @(posedge clk); #1;
    expZero("midRst");
    rst = 1'b0;                              // ch1, ch3 still ready
    at(63);  exp1("reUp63", V_UP, 0, 4'b0000);
    at(64);  exp1("reUp64", V_UP, 0, 4'b1010);
    at(79);  fec[3] = 1'b1;                  // edges 80, 81
             expRate(100, 16'h2000);
    at(81);  fec[3] = 1'b0;
    at(101);
    done = 1;
    wait (finalDone);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
